// File: rtl/note_dds_poly_pkg.sv
// Shared constants and types for the polyphonic note-to-DDS block.
package note_dds_pkg;

    localparam int NOTE_W  = 7;
    localparam int OCT_TOP = 10;
    localparam int OCT_W   = 4;
    localparam int REM_W   = 4;

    // Top-octave (notes 120..131) increments for a 32-bit accumulator at 50 MHz:
    // round(f * 2^32 / 5e7), entry 9 is A at 14080 Hz.
    localparam logic [31:0] BASE_INC [0:11] = '{
        32'd719151,  32'd761914,  32'd807220,  32'd855219,
        32'd906073,  32'd959951,  32'd1017033, 32'd1077509,
        32'd1141581, 32'd1209463, 32'd1281381, 32'd1357576
    };

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIV,
        S_LOOKUP,
        S_ALLOC
    } state_t;

    // Command latched at the handshake.
    typedef struct packed {
        logic [NOTE_W-1:0] note;
        logic              on;
    } note_cmd_t;

endpackage

// File: rtl/note_dds_poly_if.sv
// Note command channel: valid/ready handshake carrying a MIDI note and on/off flag.
interface note_dds_poly_if;
    import note_dds_pkg::*;

    logic              valid;
    logic              ready;
    logic [NOTE_W-1:0] note;
    logic              note_on;

    modport master (output valid, output note, output note_on, input ready);
    modport slave  (input valid, input note, input note_on, output ready);

endinterface

// File: rtl/note_dds_poly_div12.sv
// Sequential divide-by-12: one subtraction per cycle, splitting a MIDI note
// into octave and semitone. Done is asserted as soon as the remainder is < 12.
module note_div12
    import note_dds_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [NOTE_W-1:0] i_note,
    output logic              o_done,
    output logic [OCT_W-1:0]  o_oct,
    output logic [REM_W-1:0]  o_rem
);

    logic [NOTE_W-1:0] r_rem;
    logic [OCT_W-1:0]  r_oct;
    logic              w_ge12;

    assign w_ge12 = (r_rem >= NOTE_W'(12));

    // Load on start, then peel off one octave per cycle until the remainder fits.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rem <= '0;
            r_oct <= '0;
        end else if (i_start) begin
            r_rem <= i_note;
            r_oct <= '0;
        end else if (w_ge12) begin
            r_rem <= r_rem - NOTE_W'(12);
            r_oct <= r_oct + 1'b1;
        end
    end

    assign o_done = !w_ge12;
    assign o_oct  = r_oct;
    assign o_rem  = r_rem[REM_W-1:0];

endmodule

// File: rtl/note_dds_poly.sv
// Polyphonic note -> phase-increment DDS. Note commands are divided into
// octave/semitone, looked up, and allocated to one of VOICES accumulators.
// All busy voices accumulate every cycle; a registered sum of their phase MSBs
// forms a sawtooth mix.
module note_dds_poly
    import note_dds_pkg::*;
#(
    parameter  int VOICES = 4,
    parameter  int ACC_W  = 32,
    parameter  int OUT_W  = 16,
    localparam int MIX_W  = OUT_W + $clog2(VOICES)
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    note_dds_poly_if.slave           cmd,
    output logic [VOICES-1:0]        o_voice_busy,
    output logic [VOICES*ACC_W-1:0]  o_phase,
    output logic [MIX_W-1:0]         o_mix
);

    localparam int VW = (VOICES > 1) ? $clog2(VOICES) : 1;

    state_t                          r_state, w_next;
    logic                            r_ready;
    note_cmd_t                       r_cmd;
    logic                            w_xfer;

    logic                            w_div_done;
    logic [OCT_W-1:0]                w_oct;
    logic [REM_W-1:0]                w_rem;
    logic [OCT_W-1:0]                w_shift;
    logic [ACC_W-1:0]                w_base_scaled;
    logic [ACC_W-1:0]                r_inc_new;

    logic [VOICES-1:0]               w_busy;
    logic [VOICES-1:0][ACC_W-1:0]    w_phase;
    logic [VOICES-1:0][NOTE_W-1:0]   w_vnote;

    logic                            w_hit, w_any_free;
    logic [VW-1:0]                   w_hit_idx, w_free_idx, w_tgt_idx;
    logic [VW-1:0]                   r_steal;
    logic                            w_alloc, w_tgt_vld, w_steal;

    logic [MIX_W-1:0]                w_mix_sum, r_mix;

    assign w_xfer    = cmd.valid && r_ready;
    assign cmd.ready = r_ready;

    note_div12 u_div (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_start (w_xfer),
        .i_note  (cmd.note),
        .o_done  (w_div_done),
        .o_oct   (w_oct),
        .o_rem   (w_rem)
    );

    // Next-state: divide runs until the remainder is below 12, then one cycle
    // each for table lookup and voice allocation.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_xfer) w_next = S_DIV;
            S_DIV:    if (w_div_done) w_next = S_LOOKUP;
            S_LOOKUP: w_next = S_ALLOC;
            S_ALLOC:  w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // State register; ready is registered so it stays low throughout reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_ready <= 1'b0;
            r_cmd   <= '0;
        end else begin
            r_state <= w_next;
            r_ready <= (w_next == S_IDLE);
            if (w_xfer) r_cmd <= '{note: cmd.note, on: cmd.note_on};
        end
    end

    // Rescale the 32-bit table entry to the accumulator width.
    if (ACC_W >= 32) begin : g_scale_up
        assign w_base_scaled = ACC_W'(BASE_INC[w_rem]) << (ACC_W - 32);
    end else begin : g_scale_dn
        assign w_base_scaled = ACC_W'(BASE_INC[w_rem] >> (32 - ACC_W));
    end

    // Each octave below the top halves the increment (truncating).
    assign w_shift = OCT_W'(OCT_TOP) - w_oct;

    // Latch the increment for the pending command during LOOKUP.
    always_ff @(posedge i_clk) begin
        if (i_reset)                   r_inc_new <= '0;
        else if (r_state == S_LOOKUP)  r_inc_new <= w_base_scaled >> w_shift;
    end

    // Lowest-index voice already playing this note, and lowest-index free voice.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_idx  = '0;
        w_any_free = 1'b0;
        w_free_idx = '0;
        for (int v = VOICES - 1; v >= 0; v--) begin
            if (w_busy[v] && (w_vnote[v] == r_cmd.note)) begin
                w_hit     = 1'b1;
                w_hit_idx = VW'(v);
            end
            if (!w_busy[v]) begin
                w_any_free = 1'b1;
                w_free_idx = VW'(v);
            end
        end
    end

    // Note-off only touches a matching voice; note-on always lands somewhere.
    assign w_alloc   = (r_state == S_ALLOC);
    assign w_steal   = w_alloc && r_cmd.on && !w_hit && !w_any_free;
    assign w_tgt_vld = w_alloc && (r_cmd.on || w_hit);
    assign w_tgt_idx = w_hit ? w_hit_idx : (w_any_free ? w_free_idx : r_steal);

    // Round-robin steal pointer, advanced only when a voice is actually stolen.
    always_ff @(posedge i_clk) begin
        if (i_reset)      r_steal <= '0;
        else if (w_steal) r_steal <= (r_steal == VW'(VOICES - 1)) ? '0 : r_steal + 1'b1;
    end

    for (genvar v = 0; v < VOICES; v++) begin : g_voice
        logic              w_sel;
        logic              r_b;
        logic [ACC_W-1:0]  r_ph;
        logic [ACC_W-1:0]  r_in;
        logic [NOTE_W-1:0] r_nt;

        assign w_sel = w_tgt_vld && (w_tgt_idx == VW'(v));

        // Voice state: allocation overrides accumulation; a retrigger of the
        // same note keeps running phase and only swaps the increment.
        always_ff @(posedge i_clk) begin
            if (i_reset) begin
                r_b  <= 1'b0;
                r_ph <= '0;
                r_in <= '0;
                r_nt <= '0;
            end else if (w_sel && r_cmd.on) begin
                r_b  <= 1'b1;
                r_in <= r_inc_new;
                r_nt <= r_cmd.note;
                r_ph <= w_hit ? r_ph + r_in : '0;
            end else if (w_sel) begin
                r_b  <= 1'b0;
                r_in <= '0;
                r_ph <= '0;
            end else if (r_b) begin
                r_ph <= r_ph + r_in;
            end
        end

        assign w_busy[v]                   = r_b;
        assign w_phase[v]                  = r_ph;
        assign w_vnote[v]                  = r_nt;
        assign o_phase[v*ACC_W +: ACC_W]   = r_ph;
    end

    // Sum of busy voices' phase MSBs; width has room for every voice at full scale.
    always_comb begin
        w_mix_sum = '0;
        for (int v = 0; v < VOICES; v++) begin
            if (w_busy[v]) w_mix_sum = w_mix_sum + MIX_W'(w_phase[v][ACC_W-1 -: OUT_W]);
        end
    end

    // Mix register (one cycle behind the phases it sums).
    always_ff @(posedge i_clk) begin
        if (i_reset) r_mix <= '0;
        else         r_mix <= w_mix_sum;
    end

    assign o_voice_busy = w_busy;
    assign o_mix        = r_mix;

endmodule

// File: tb/tb_note_dds_poly.sv
// Directed bench for note_dds_poly with VOICES=4, ACC_W=32, OUT_W=16.
module tb_note_dds_poly;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   busy;
    logic [127:0] phase;
    logic [17:0]  mix;
    int           tests = 0;
    int           fails = 0;

    note_dds_poly_if cmd_if ();

    note_dds_poly #(.VOICES(4), .ACC_W(32), .OUT_W(16)) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .cmd          (cmd_if),
        .o_voice_busy (busy),
        .o_phase      (phase),
        .o_mix        (mix)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ph(input int v);
        return phase[v*32 +: 32];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One transfer, then count negedges with ready low (bounded).
    task automatic send(input logic [6:0] n, input logic on, input int exp_lat, input string tag);
        int cnt;
        cmd_if.valid   = 1'b1;
        cmd_if.note    = n;
        cmd_if.note_on = on;
        @(posedge clk);
        @(negedge clk);
        cmd_if.valid = 1'b0;
        cnt = 0;
        while (cmd_if.ready !== 1'b1 && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
        check(tag, cnt, exp_lat);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        step(n);
        rst = 1'b0;
        step(1);
    endtask

    initial begin
        rst            = 1'b1;
        cmd_if.valid   = 1'b0;
        cmd_if.note    = '0;
        cmd_if.note_on = 1'b0;

        // Reset state
        step(5);
        check("rst_phase", phase, 0);
        check("rst_mix",   mix,   0);
        check("rst_busy",  busy,  0);
        check("rst_ready", cmd_if.ready, 0);
        rst = 1'b0;
        step(1);
        check("rst_ready_after", cmd_if.ready, 1);

        // Single note 69: oct 5, inc 37795
        send(7'd69, 1'b1, 8, "lat69");
        check("n69_busy",  busy, 4'b0001);
        check("n69_ph0",   ph(0), 0);
        step(1);
        check("n69_inc",   ph(0), 37795);
        step(999);
        check("n69_1000",  ph(0), 37795000);
        check("n69_mix",   mix, 576);

        // Fill four voices, then steal voice 0 with 76 and voice 1 with 79
        do_reset(2);
        send(7'd60, 1'b1, 8, "lat60");
        send(7'd64, 1'b1, 8, "lat64");
        send(7'd67, 1'b1, 8, "lat67");
        send(7'd72, 1'b1, 9, "lat72");
        check("fill_busy", busy, 4'b1111);
        send(7'd76, 1'b1, 9, "lat76");
        check("steal0_busy", busy, 4'b1111);
        check("steal0_ph",   ph(0), 0);
        step(10);
        check("steal0_inc",  ph(0), 566290);
        send(7'd79, 1'b1, 9, "lat79");
        check("steal1_ph",   ph(1), 0);
        step(3);
        check("steal1_inc",  ph(1), 202032);
        check("steal0_run",  ph(0), 1302467);

        // Note-off present and absent
        do_reset(2);
        send(7'd60, 1'b1, 8, "lat60b");
        send(7'd64, 1'b1, 8, "lat64b");
        send(7'd67, 1'b1, 8, "lat67b");
        send(7'd72, 1'b1, 9, "lat72b");
        send(7'd64, 1'b0, 8, "latoff64");
        check("off64_busy", busy, 4'b1101);
        check("off64_ph",   ph(1), 0);
        step(5);
        check("off64_hold", ph(1), 0);
        send(7'd50, 1'b0, 7, "latoff50");
        check("off50_busy", busy, 4'b1101);
        check("off50_ph1",  ph(1), 0);

        // Note 127: top octave, wraps after 3986 adds
        do_reset(2);
        send(7'd127, 1'b1, 13, "lat127");
        check("n127_busy",  busy, 4'b0001);
        step(3986);
        check("wrap_pre",   ph(0), 32'd4294950874);
        step(1);
        check("wrap_post",  ph(0), 1061087);
        check("wrap_mix_a", mix, 65535);
        step(1);
        check("wrap_mix_b", mix, 16);

        // Reset during DIV of note 100 discards the command
        do_reset(2);
        cmd_if.valid   = 1'b1;
        cmd_if.note    = 7'd100;
        cmd_if.note_on = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_if.valid = 1'b0;
        check("div_ready_lo", cmd_if.ready, 0);
        step(2);
        rst = 1'b1;
        step(2);
        check("midrst_ready", cmd_if.ready, 0);
        rst = 1'b0;
        step(1);
        check("midrst_ready1", cmd_if.ready, 1);
        step(20);
        check("midrst_busy",  busy, 0);
        check("midrst_phase", phase, 0);
        check("midrst_mix",   mix, 0);
        check("midrst_idle",  cmd_if.ready, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
